// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: functional-unit codes,
// GPR/data widths and the packed result entry stored in the per-unit FIFOs.
package writeback_arbiter_pkg;

    localparam int unsigned UNIT_FX         = 0;
    localparam int unsigned UNIT_FP         = 1;
    localparam int unsigned UNIT_LDST       = 2;
    localparam int unsigned UNIT_BRANCH     = 3;
    localparam int unsigned UNIT_CODE_WIDTH = 2;

    localparam int unsigned GPR_ADDR_WIDTH  = 5;
    localparam int unsigned WB_DATA_WIDTH   = 64;

    typedef struct packed {
        logic [GPR_ADDR_WIDTH-1:0] reg_addr;
        logic [WB_DATA_WIDTH-1:0]  data;
    } wb_result_t;

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Single-clock FIFO with count/full/empty flags and synchronous reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
            else if (!do_push && do_pop) count <= count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Per-unit result FIFOs round-robin arbitrated onto the single GPR write port.
// Optional per-unit stall counters are built only when WB_PERF_COUNTERS_EN is defined.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned NUM_UNITS  = 4,
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
    parameter int unsigned REG_WIDTH  = GPR_ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic [NUM_UNITS-1:0]            resValid_i,
    output logic [NUM_UNITS-1:0]            resReady_o,
    input  logic [NUM_UNITS*REG_WIDTH-1:0]  resRegAddr_i,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] resData_i,
    output logic                            wbEnable_o,
    output logic [REG_WIDTH-1:0]            wbRegAddr_o,
    output logic [DATA_WIDTH-1:0]           wbData_o,
    output logic [UNIT_CODE_WIDTH-1:0]      wbUnit_o,
    output logic [NUM_UNITS*CNT_WIDTH-1:0]  stallCount_o
);

    localparam int unsigned IDX_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned ENTRY_W = REG_WIDTH + DATA_WIDTH;
    localparam int unsigned FILL_W  = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_UNITS-1:0] fifo_push;
    logic [NUM_UNITS-1:0] fifo_pop;
    logic [NUM_UNITS-1:0] fifo_full;
    logic [NUM_UNITS-1:0] fifo_empty;
    logic [FILL_W-1:0]    fifo_count [NUM_UNITS];
    logic [ENTRY_W-1:0]   fifo_head  [NUM_UNITS];

    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        // Ready comes from the registered fill level only, so a full FIFO
        // never accepts in the cycle it is popped.
        assign resReady_o[u] = (fifo_count[u] < FILL_W'(FIFO_DEPTH));
        assign fifo_push[u]  = resValid_i[u] && !fifo_full[u];
        assign fifo_pop[u]   = grant_valid && (grant_idx == IDX_W'(u));

        wb_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clk   (clock_i),
            .rst   (reset_i),
            .push  (fifo_push[u]),
            .wdata ({resRegAddr_i[u*REG_WIDTH +: REG_WIDTH], resData_i[u*DATA_WIDTH +: DATA_WIDTH]}),
            .pop   (fifo_pop[u]),
            .rdata (fifo_head[u]),
            .count (fifo_count[u]),
            .full  (fifo_full[u]),
            .empty (fifo_empty[u])
        );
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 1; i <= NUM_UNITS; i++) begin
            if (!grant_valid && !fifo_empty[IDX_W'((32'(rr_ptr) + i) % NUM_UNITS)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'((32'(rr_ptr) + i) % NUM_UNITS);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rr_ptr      <= IDX_W'(NUM_UNITS - 1);
            wbEnable_o  <= 1'b0;
            wbRegAddr_o <= '0;
            wbData_o    <= '0;
            wbUnit_o    <= '0;
        end else begin
            wbEnable_o <= grant_valid;
            if (grant_valid) begin
                rr_ptr                  <= grant_idx;
                {wbRegAddr_o, wbData_o} <= fifo_head[grant_idx];
                wbUnit_o                <= UNIT_CODE_WIDTH'(grant_idx);
            end
        end
    end

`ifdef WB_PERF_COUNTERS_EN
    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_stall
        logic [CNT_WIDTH-1:0] stall_cnt;

        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                stall_cnt <= '0;
            end else if (resValid_i[u] && !resReady_o[u] && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
        end

        assign stallCount_o[u*CNT_WIDTH +: CNT_WIDTH] = stall_cnt;
    end
`else
    assign stallCount_o = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed stimulus pushes expected writes
// (unit, address, data, cycle) into a queue; a negedge monitor pops and compares.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int unsigned NU = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned RW = 5;
    localparam int unsigned FD = 2;
    localparam int unsigned CW = 32;

    logic                clk = 1'b0;
    logic                reset_i;
    logic [NU-1:0]       res_valid;
    logic [NU-1:0]       res_ready;
    logic [NU*RW-1:0]    res_addr;
    logic [NU*DW-1:0]    res_data;
    logic                wb_en;
    logic [RW-1:0]       wb_addr;
    logic [DW-1:0]       wb_data;
    logic [1:0]          wb_unit;
    logic [NU*CW-1:0]    stall_count;

    writeback_arbiter #(
        .NUM_UNITS  (NU),
        .DATA_WIDTH (DW),
        .REG_WIDTH  (RW),
        .FIFO_DEPTH (FD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock_i      (clk),
        .reset_i      (reset_i),
        .resValid_i   (res_valid),
        .resReady_o   (res_ready),
        .resRegAddr_i (res_addr),
        .resData_i    (res_data),
        .wbEnable_o   (wb_en),
        .wbRegAddr_o  (wb_addr),
        .wbData_o     (wb_data),
        .wbUnit_o     (wb_unit),
        .stallCount_o (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned unit;
        wb_result_t  res;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned fails = 0;
    int unsigned seen[NU];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int unsigned u, input logic [RW-1:0] a, input logic [DW-1:0] d);
        res_valid[u]          = 1'b1;
        res_addr[u*RW +: RW]  = a;
        res_data[u*DW +: DW]  = d;
    endtask

    task automatic expect_wb(input int unsigned u, input logic [RW-1:0] a, input logic [DW-1:0] d,
                             input int unsigned c);
        exp_t e;
        e.unit         = u;
        e.res.reg_addr = a;
        e.res.data     = d;
        e.cyc          = c;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset_i   = 1'b1;
        res_valid = '0;
        next_cycle();
        next_cycle();
        reset_i   = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) next_cycle();
        repeat (3) next_cycle();
        check(name, sb.size(), 0);
    endtask

    // Monitor: every write strobe must match the head of the scoreboard, cycle included.
    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            seen[wb_unit]++;
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: cycle %0d unit %0d addr %0d data %0h, expected no write",
                         cyc, wb_unit, wb_addr, wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("wb_u%0d_r%0d", e.unit, e.res.reg_addr),
                      {32'(cyc), wb_unit, wb_addr, wb_data},
                      {32'(e.cyc), 2'(e.unit), e.res});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        int unsigned kf, kl;
        logic acc_f, acc_l;

        res_addr = '0;
        res_data = '0;
        do_reset();

        // Reset state
        check("rst_en",    wb_en,     1'b0);
        check("rst_addr",  wb_addr,   0);
        check("rst_data",  wb_data,   0);
        check("rst_unit",  wb_unit,   0);
        check("rst_ready", res_ready, 4'hF);

        // 1: single uncontested FX result, two-cycle latency, single pulse
        next_cycle();
        next_cycle();
        t = cyc;
        expect_wb(UNIT_FX, 5'd3, 64'h1234, t + 2);
        drive(UNIT_FX, 5'd3, 64'h1234);
        next_cycle();
        res_valid = '0;
        drain("t1_drain");

        // 2: all four units in one cycle, served 0,1,2,3
        do_reset();
        t = cyc;
        for (int unsigned u = 0; u < NU; u++) begin
            expect_wb(u, 5'(u + 1), 64'hA0 + 64'(u), t + 2 + u);
            drive(u, 5'(u + 1), 64'hA0 + 64'(u));
        end
        next_cycle();
        res_valid = '0;
        check("t2_ready_t1", res_ready, 4'hF);
        next_cycle();
        check("t2_ready_t2", res_ready, 4'hF);
        drain("t2_drain");

        // 3: FP fills, ready drops, held value is accepted once FP drains
        do_reset();
        t = cyc;
        expect_wb(UNIT_FX, 5'd5, 64'hF0, t + 2);
        expect_wb(UNIT_FP, 5'd6, 64'hA,  t + 3);
        expect_wb(UNIT_FX, 5'd5, 64'hF1, t + 4);
        expect_wb(UNIT_FP, 5'd6, 64'hB,  t + 5);
        expect_wb(UNIT_FP, 5'd6, 64'hC,  t + 6);
        drive(UNIT_FX, 5'd5, 64'hF0);
        drive(UNIT_FP, 5'd6, 64'hA);
        next_cycle();
        check("t3_ready_t1", res_ready[1:0], 2'b11);
        drive(UNIT_FX, 5'd5, 64'hF1);
        drive(UNIT_FP, 5'd6, 64'hB);
        next_cycle();
        check("t3_fp_full", res_ready[UNIT_FP], 1'b0);
        res_valid[UNIT_FX] = 1'b0;
        drive(UNIT_FP, 5'd6, 64'hC);
        next_cycle();
        check("t3_fp_ready_again", res_ready[UNIT_FP], 1'b1);
        next_cycle();
        res_valid = '0;
        check("t3_fp_full_again", res_ready[UNIT_FP], 1'b0);
        drain("t3_drain");

        // 4: FX and LdSt streaming; grants alternate 0,2,... (LdSt writes GPR 0)
        do_reset();
        for (int unsigned u = 0; u < NU; u++) seen[u] = 0;
        t = cyc;
        for (int unsigned k = 0; k < 6; k++) begin
            expect_wb(UNIT_FX,   5'd7, 64'hF000 + 64'(k), t + 2 + 2*k);
            expect_wb(UNIT_LDST, 5'd0, 64'h2000 + 64'(k), t + 3 + 2*k);
        end
        kf = 0;
        kl = 0;
        for (int i = 0; i < 40 && (kf < 6 || kl < 6); i++) begin
            res_valid = '0;
            if (kf < 6) drive(UNIT_FX,   5'd7, 64'hF000 + 64'(kf));
            if (kl < 6) drive(UNIT_LDST, 5'd0, 64'h2000 + 64'(kl));
            acc_f = (kf < 6) && res_ready[UNIT_FX];
            acc_l = (kl < 6) && res_ready[UNIT_LDST];
            next_cycle();
            if (acc_f) kf++;
            if (acc_l) kl++;
        end
        res_valid = '0;
        drain("t4_drain");
        check("t4_fx_share",   seen[UNIT_FX],   6);
        check("t4_ldst_share", seen[UNIT_LDST], 6);

        // 5: reset with three entries queued discards them
        do_reset();
        drive(UNIT_FX,   5'd8,  64'h88);
        drive(UNIT_FP,   5'd9,  64'h99);
        drive(UNIT_LDST, 5'd10, 64'hAA);
        next_cycle();
        res_valid = '0;
        reset_i   = 1'b1;
        next_cycle();
        reset_i   = 1'b0;
        check("t5_en",    wb_en,     1'b0);
        check("t5_addr",  wb_addr,   0);
        check("t5_data",  wb_data,   0);
        check("t5_unit",  wb_unit,   0);
        check("t5_ready", res_ready, 4'hF);
        repeat (4) next_cycle();
        t = cyc;
        expect_wb(UNIT_FX, 5'd11, 64'h5555, t + 2);
        drive(UNIT_FX, 5'd11, 64'h5555);
        next_cycle();
        res_valid = '0;
        drain("t5_drain");

        // 6: Branch held against a full FIFO for five stalled cycles
        do_reset();
        t = cyc;
        expect_wb(UNIT_FX,     5'd1, 64'h10, t + 2);
        expect_wb(UNIT_FP,     5'd2, 64'h20, t + 3);
        expect_wb(UNIT_LDST,   5'd3, 64'h30, t + 4);
        expect_wb(UNIT_BRANCH, 5'd4, 64'h40, t + 5);
        expect_wb(UNIT_FX,     5'd1, 64'h11, t + 6);
        expect_wb(UNIT_FP,     5'd2, 64'h21, t + 7);
        expect_wb(UNIT_LDST,   5'd3, 64'h31, t + 8);
        expect_wb(UNIT_BRANCH, 5'd4, 64'h41, t + 9);
        expect_wb(UNIT_BRANCH, 5'd4, 64'h42, t + 10);
        for (int unsigned u = 0; u < NU; u++) drive(u, 5'(u + 1), 64'(16*(u + 1)));
        next_cycle();
        for (int unsigned u = 0; u < NU; u++) drive(u, 5'(u + 1), 64'(16*(u + 1) + 1));
        next_cycle();
        res_valid = '0;
        drive(UNIT_BRANCH, 5'd4, 64'h42);
        check("t6_br_full", res_ready[UNIT_BRANCH], 1'b0);
        repeat (4) next_cycle();
        drive(UNIT_BRANCH, 5'd4, 64'h43);
        repeat (2) next_cycle();
        res_valid = '0;
        repeat (3) next_cycle();
`ifdef WB_PERF_COUNTERS_EN
        check("t6_stall_count", stall_count, {32'd5, 96'd0});
`else
        check("t6_stall_count", stall_count, 128'd0);
`endif
        drain("t6_drain");

        check("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
